// File: rtl/config_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : config_arb_pkg
// Description : Shared types and constants for the configuration-port arbiter.
//               Holds the arbiter state enum, the source index constants and
//               the configuration data width, plus a small popcount helper.
// Revision    : 1.0 - initial release
// ============================================================================
package config_arb_pkg;

    localparam int DATA_W = 32;

    // Source indices double as priority: lower index wins.
    localparam logic [1:0] SRC_UART    = 2'd0;
    localparam logic [1:0] SRC_JTAG    = 2'd1;
    localparam logic [1:0] SRC_BITBANG = 2'd2;
    localparam logic [1:0] SRC_SELF    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWNED   = 2'd1,
        ST_HOLDOFF = 2'd2
    } arb_state_t;

    // Number of set bits in a 4-bit strobe mask.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/config_arb_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : config_arb_prio_enc
// Description : Combinational lowest-index-first priority encoder over a
//               4-bit request mask.
// Ports       : mask  in  4 - request bits
//               idx   out 2 - index of the lowest set bit (0 when none)
//               valid out 1 - at least one bit of mask is set
// Revision    : 1.0 - initial release
// ============================================================================
module config_arb_prio_enc (
    input  logic [3:0] mask,
    output logic [1:0] idx,
    output logic       valid
);

    always_comb begin
        idx   = 2'd0;
        valid = |mask;
        // Scan from the top down so the lowest set bit is written last.
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) begin
                idx = 2'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/config_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : config_port_arbiter
// Description : Session-based arbiter sharing the ConfigFSM write port among
//               four sources (0=UART, 1=JTAG, 2=BitBang, 3=Self). A granted
//               source owns the port until it deactivates and a hold-off
//               expires. FSM_Reset pulses once per new session. Strobes from
//               non-owners (or any strobe while idle) are dropped and counted.
//               Optional preemption by a higher-priority source is enabled by
//               defining CONFIG_ARB_PREEMPT_EN.
// Ports       : CLK               in  1   - configuration clock
//               resetn            in  1   - synchronous active-low reset
//               src_active        in  4   - per-source session-active flag
//               src_data          in  128 - per-source data, source i at [32i+:32]
//               src_strobe        in  4   - per-source write strobe
//               ConfigWriteData   out 32  - registered write data
//               ConfigWriteStrobe out 1   - registered write strobe
//               FSM_Reset         out 1   - pulse at session start
//               owner             out 2   - current owner index
//               owner_valid       out 1   - a session is open (OWNED/HOLDOFF)
//               drop_pulse        out 1   - pulse when any strobe is dropped
//               drop_count        out DROP_CNT_W - saturating drop counter
// Revision    : 1.0 - initial release
// ============================================================================
module config_port_arbiter
    import config_arb_pkg::*;
#(
    parameter int NUM_SRC        = 4,
    parameter int HOLDOFF_CYCLES = 16,
    parameter int DROP_CNT_W     = 8
) (
    input  logic                      CLK,
    input  logic                      resetn,
    input  logic [NUM_SRC-1:0]        src_active,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_strobe,
    output logic [DATA_W-1:0]         ConfigWriteData,
    output logic                      ConfigWriteStrobe,
    output logic                      FSM_Reset,
    output logic [1:0]                owner,
    output logic                      owner_valid,
    output logic                      drop_pulse,
    output logic [DROP_CNT_W-1:0]     drop_count
);

    localparam int SUM_W = DROP_CNT_W + 3;

    arb_state_t              r_state,       w_state_nxt;
    logic [1:0]              r_owner,       w_owner_nxt;
    logic [7:0]              r_hold_cnt,    w_hold_cnt_nxt;
    logic [DATA_W-1:0]       r_wr_data,     w_wr_data_nxt;
    logic                    r_wr_strobe,   w_wr_strobe_nxt;
    logic                    r_fsm_reset,   w_fsm_reset_nxt;
    logic                    r_drop_pulse,  w_drop_pulse_nxt;
    logic [DROP_CNT_W-1:0]   r_drop_count,  w_drop_count_nxt;

    logic [NUM_SRC-1:0]      w_dropped;
    logic [NUM_SRC-1:0]      w_owner_oh;
    logic [SUM_W-1:0]        w_drop_sum;
    logic [1:0]              w_grant_idx;
    logic                    w_grant_valid;
    logic                    w_preempt;
    logic [1:0]              w_preempt_idx;
    logic [DATA_W-1:0]       w_src_word [NUM_SRC];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign w_src_word[gi] = src_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign w_owner_oh = 4'b0001 << r_owner;

    config_arb_prio_enc u_grant_enc (
        .mask  (src_active),
        .idx   (w_grant_idx),
        .valid (w_grant_valid)
    );

`ifdef CONFIG_ARB_PREEMPT_EN
    // Only sources strictly above the owner in priority may preempt.
    logic [NUM_SRC-1:0] w_higher_mask;

    assign w_higher_mask = src_active & 4'(w_owner_oh - 4'd1);

    config_arb_prio_enc u_preempt_enc (
        .mask  (w_higher_mask),
        .idx   (w_preempt_idx),
        .valid (w_preempt)
    );
`else
    assign w_preempt     = 1'b0;
    assign w_preempt_idx = 2'd0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_wr_data_nxt   = r_wr_data;
        w_wr_strobe_nxt = 1'b0;
        w_fsm_reset_nxt = 1'b0;
        w_dropped       = src_strobe & ~w_owner_oh;

        case (r_state)
            ST_IDLE: begin
                // Nothing is forwarded while idle, including a strobe from
                // the source being granted this very cycle.
                w_dropped = src_strobe;
                if (w_grant_valid) begin
                    w_state_nxt     = ST_OWNED;
                    w_owner_nxt     = w_grant_idx;
                    w_fsm_reset_nxt = 1'b1;
                end
            end

            ST_OWNED, ST_HOLDOFF: begin
                if (w_preempt) begin
                    // Switch cycle: every strobe is dropped, the hold-off is
                    // abandoned and the new session starts with a reset.
                    w_dropped       = src_strobe;
                    w_state_nxt     = ST_OWNED;
                    w_owner_nxt     = w_preempt_idx;
                    w_fsm_reset_nxt = 1'b1;
                    w_hold_cnt_nxt  = 8'd0;
                end else begin
                    if (src_strobe[r_owner]) begin
                        w_wr_strobe_nxt = 1'b1;
                        w_wr_data_nxt   = w_src_word[r_owner];
                    end

                    if (r_state == ST_OWNED) begin
                        if (!src_active[r_owner]) begin
                            w_hold_cnt_nxt = 8'(HOLDOFF_CYCLES - 1);
                            w_state_nxt    = ST_HOLDOFF;
                        end
                    end else if (src_active[r_owner]) begin
                        w_state_nxt = ST_OWNED;
                    end else if (r_hold_cnt == 8'd0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_hold_cnt_nxt = r_hold_cnt - 8'd1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Each dropped strobe counts once; the counter sticks at all-ones.
        w_drop_pulse_nxt = |w_dropped;
        w_drop_sum       = {3'b000, r_drop_count} + SUM_W'(popcount4(w_dropped));
        if (w_drop_sum > {3'b000, {DROP_CNT_W{1'b1}}}) begin
            w_drop_count_nxt = {DROP_CNT_W{1'b1}};
        end else begin
            w_drop_count_nxt = w_drop_sum[DROP_CNT_W-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_owner      <= 2'd0;
            r_hold_cnt   <= 8'd0;
            r_wr_data    <= '0;
            r_wr_strobe  <= 1'b0;
            r_fsm_reset  <= 1'b0;
            r_drop_pulse <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
            r_wr_data    <= w_wr_data_nxt;
            r_wr_strobe  <= w_wr_strobe_nxt;
            r_fsm_reset  <= w_fsm_reset_nxt;
            r_drop_pulse <= w_drop_pulse_nxt;
            r_drop_count <= w_drop_count_nxt;
        end
    end

    assign ConfigWriteData   = r_wr_data;
    assign ConfigWriteStrobe = r_wr_strobe;
    assign FSM_Reset         = r_fsm_reset;
    assign owner             = r_owner;
    assign owner_valid       = (r_state != ST_IDLE);
    assign drop_pulse        = r_drop_pulse;
    assign drop_count        = r_drop_count;

endmodule

`default_nettype wire

// File: doc/config_port_arbiter.md
# config_port_arbiter

Session-based arbiter that shares the single configuration write port (32-bit data plus strobe) in front of `ConfigFSM` between four configuration sources: UART, JTAG, bit-bang and internal self-write. A source that raises its active flag is granted the port for a whole session, and it keeps the port until it deactivates and a hold-off expires. `FSM_Reset` pulses exactly once at the start of each new session. Writes from non-owners are dropped and counted. The block sits between the source front-ends and `ConfigFSM` inside the fabric configuration wrapper.

## Interface
Parameters:
- `NUM_SRC`, 4: number of sources, fixed at 4. Priority is index order: 0=UART (highest), 1=JTAG, 2=BitBang, 3=Self.
- `HOLDOFF_CYCLES`, 16: idle cycles after the owner deactivates before the port is re-arbitrated; range 1..255.
- `DROP_CNT_W`, 8: width of the dropped-write counter.

Ports (one clock; reset is synchronous and active-low):
- `CLK` in 1: configuration clock.
- `resetn` in 1: synchronous, active-low reset.
- `src_active` in 4: per-source session-active flag.
- `src_data` in 128: per-source write data; source i is on bits [32i+31:32i].
- `src_strobe` in 4: per-source one-cycle write strobe.
- `ConfigWriteData` out 32: registered data to `ConfigFSM`.
- `ConfigWriteStrobe` out 1: registered strobe to `ConfigFSM`.
- `FSM_Reset` out 1: one-cycle pulse at session start.
- `owner` out 2: index of the current owner.
- `owner_valid` out 1: high in OWNED and HOLDOFF.
- `drop_pulse` out 1: one-cycle pulse for each dropped strobe.
- `drop_count` out `DROP_CNT_W`: saturating count of dropped strobes.

## Operation
States and transitions:
- IDLE: no owner.
  - If any `src_active` bit is set, grant the lowest-index active source: latch `owner`, go to OWNED, assert `FSM_Reset` for the next cycle.
- OWNED:
  - An owner strobe forwards that source's data and strobe.
  - If the owner's `src_active` is low, load the hold-off counter with `HOLDOFF_CYCLES`-1 and go to HOLDOFF.
- HOLDOFF: the counter decrements every cycle.
  - If the owner reasserts active: return to OWNED with no `FSM_Reset`, and the session continues.
  - If the counter reaches 0 with the owner still inactive: go to IDLE, clear `owner_valid`, and re-arbitrate in the following cycle.
  - An owner strobe during HOLDOFF is still forwarded.

Dropped writes:
- A strobe from any non-owner, or any strobe in IDLE, is dropped.
- A dropped strobe raises `drop_pulse` and increments `drop_count`, which saturates at all-ones.
- When several strobes drop in the same cycle, `drop_pulse` is a single pulse and `drop_count` adds 1 per dropped strobe, still saturating.

Other rules:
- A strobe from the granting source in the grant cycle (IDLE→OWNED) is dropped, because a source must raise active at least 1 cycle before its first strobe.
- With the macro off, a higher-priority source going active while another source owns the port does not preempt it.

## Timing
Reset values:
- Every output resets to 0.
- The state machine resets to IDLE and the hold-off counter resets to 0.
- If `resetn` is low mid-session, the next cycle is IDLE with no owner and no `FSM_Reset` pulse.

Latency:
- Owner strobe in cycle t appears on `ConfigWriteStrobe`/`ConfigWriteData` in cycle t+1.
- `ConfigWriteData` holds its last forwarded value between strobes.
- `src_active` rising in IDLE at cycle t gives `owner_valid` and `FSM_Reset` in cycle t+1; the first owner strobe is accepted at t+1 and forwarded at t+2.
- Owner active falling at cycle t enters HOLDOFF at t+1. IDLE is reached at t+1+`HOLDOFF_CYCLES`, with `owner_valid` low in that same cycle.

Throughput and ordering:
- One word per cycle is sustained with no back-pressure.
- `FSM_Reset` and `ConfigWriteStrobe` are never high in the same cycle.

## Configuration
- `CONFIG_ARB_PREEMPT_EN` defined:
  - In OWNED or HOLDOFF, any active source with a lower index than `owner` preempts immediately.
  - `owner` switches in the next cycle, `FSM_Reset` pulses, the hold-off is cancelled, and strobes from the old owner in the switch cycle are dropped.
- `CONFIG_ARB_PREEMPT_EN` undefined:
  - Strictly non-preemptive; a session ends only through HOLDOFF expiry.

## Structure
- Shared package `config_arb_pkg` holds:
  - the state enum (IDLE, OWNED, HOLDOFF);
  - source index constants `SRC_UART`, `SRC_JTAG`, `SRC_BITBANG`, `SRC_SELF`;
  - the data width constant 32.
- One sub-module, `config_arb_prio_enc`: combinational lowest-index-first encoder over a 4-bit mask, giving an index and a valid flag. It is used both for the grant and for the preemption check.

## Test plan
- **Basic session:** Self active, strobes 0xDEADBEEF and 0x12345678 two cycles apart. Expect `FSM_Reset` 1 cycle after active, and both words out 1 cycle after each strobe, with `owner`=3.
- **Simultaneous start:** UART and BitBang raise active in the same cycle. Expect `owner`=0; BitBang strobe 0xA5A5A5A5 dropped, `drop_pulse` high, `drop_count`=1.
- **Hold-off re-entry:** JTAG deasserts for 5 cycles with `HOLDOFF_CYCLES`=16, then reasserts. Expect `owner_valid` stays high, no second `FSM_Reset`, and the next strobe is forwarded.
- **Hold-off expiry:** JTAG drops while BitBang is active. Expect IDLE exactly 16 cycles after entering HOLDOFF, then a BitBang grant and an `FSM_Reset` pulse.
- **Preemption:**
  - Macro defined: Self owns, UART raises active; expect `owner`=0 the next cycle plus an `FSM_Reset` pulse.
  - Macro undefined: `owner` stays 3.
- **Saturation and reset:** 300 non-owner strobes with `DROP_CNT_W`=8 give `drop_count`=255. Then `resetn` low for 1 cycle mid-session; expect all outputs 0 and state IDLE.
